// File: rtl/cache_request_arbiter_if.sv
// Request/cache handshake bundle for cache_request_arbiter.
// master = processors + cache stage side, slave = arbiter side.
//   req_valid/req_ready/req_n/req_addr : per-processor request channel
//   cache_valid/cache_ready/cache_*    : decoded head request to lookup
//   occupancy/illegal_count            : status
interface cache_request_arbiter_if #(
    parameter int NUM_PROCS  = 3,
    parameter int FIFO_DEPTH = 4
);
    localparam int OCC_W = $clog2(FIFO_DEPTH) + 1;

    logic [NUM_PROCS-1:0]    req_valid;
    logic [NUM_PROCS-1:0]    req_ready;
    logic [4*NUM_PROCS-1:0]  req_n;
    logic [32*NUM_PROCS-1:0] req_addr;

    logic                    cache_valid;
    logic                    cache_ready;
    logic [3:0]              cache_n;
    logic [11:0]             cache_tag;
    logic [13:0]             cache_set;
    logic [5:0]              cache_offset;
    logic [2:0]              cache_pid;
    logic                    cache_isel;

    logic [OCC_W-1:0]        occupancy;
    logic [7:0]              illegal_count;

    modport master (
        output req_valid,
        output req_n,
        output req_addr,
        output cache_ready,
        input  req_ready,
        input  cache_valid,
        input  cache_n,
        input  cache_tag,
        input  cache_set,
        input  cache_offset,
        input  cache_pid,
        input  cache_isel,
        input  occupancy,
        input  illegal_count
    );

    modport slave (
        input  req_valid,
        input  req_n,
        input  req_addr,
        input  cache_ready,
        output req_ready,
        output cache_valid,
        output cache_n,
        output cache_tag,
        output cache_set,
        output cache_offset,
        output cache_pid,
        output cache_isel,
        output occupancy,
        output illegal_count
    );
endinterface

// File: rtl/cache_request_arbiter.sv
// Round-robin request arbiter + FIFO + address decode in front of L1.
// Ports: clk, rst (async, active-high), bus (cache_request_arbiter_if.slave).
module cache_request_arbiter #(
    parameter int NUM_PROCS  = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    cache_request_arbiter_if.slave  bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int OW = AW + 1;
    localparam logic [OW-1:0] DEPTH_C = OW'(FIFO_DEPTH);
    localparam logic [2:0]    LAST_P  = 3'(NUM_PROCS - 1);

    // Request lanes widened to 8 so a 3-bit pid indexes them cleanly.
    logic [7:0]  w_valid8;
    logic [3:0]  w_n_arr    [8];
    logic [31:0] w_addr_arr [8];

    always_comb begin
        w_valid8 = '0;
        w_valid8[NUM_PROCS-1:0] = bus.req_valid;
    end

    for (genvar g = 0; g < 8; g++) begin : g_lane
        if (g < NUM_PROCS) begin : g_on
            assign w_n_arr[g]    = bus.req_n[4*g +: 4];
            assign w_addr_arr[g] = bus.req_addr[32*g +: 32];
        end else begin : g_off
            assign w_n_arr[g]    = 4'd0;
            assign w_addr_arr[g] = 32'd0;
        end
    end

    logic [2:0]    r_rr;
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [OW-1:0] r_occ;
    logic [7:0]    r_ill;

    logic [3:0]    r_mem_n    [FIFO_DEPTH];
    logic [31:0]   r_mem_addr [FIFO_DEPTH];
    logic [2:0]    r_mem_pid  [FIFO_DEPTH];

    logic [3:0]    w_sum;
    logic          w_found;
    logic [2:0]    w_winner;
    logic [2:0]    w_rr_next;
    logic          w_full;
    logic          w_grant;
    logic          w_legal;
    logic          w_push;
    logic          w_pop;
    logic          w_cvalid;
    logic [7:0]    w_ready8;
    logic [3:0]    w_win_n;
    logic [31:0]   w_win_addr;

    // First valid requester scanning rr, rr+1, ... modulo NUM_PROCS.
    always_comb begin
        w_found  = 1'b0;
        w_winner = 3'd0;
        w_sum    = 4'd0;
        for (int k = 0; k < NUM_PROCS; k++) begin
            w_sum = {1'b0, r_rr} + 4'(k);
            if (w_sum >= 4'(NUM_PROCS)) begin
                w_sum = w_sum - 4'(NUM_PROCS);
            end
            if (!w_found && w_valid8[w_sum[2:0]]) begin
                w_found  = 1'b1;
                w_winner = w_sum[2:0];
            end
        end
    end

    assign w_win_n    = w_n_arr[w_winner];
    assign w_win_addr = w_addr_arr[w_winner];
    assign w_rr_next  = (w_winner == LAST_P) ? 3'd0 : w_winner + 3'd1;

    // Full uses registered occupancy, so a same-cycle pop never frees a
    // slot; illegal opcodes are held off too, keeping grant order simple.
    assign w_full   = (r_occ == DEPTH_C);
    assign w_grant  = w_found && !w_full && !rst;
    assign w_legal  = (w_win_n <= 4'd4);
    assign w_push   = w_grant && w_legal;
    assign w_cvalid = (r_occ != '0);
    assign w_pop    = w_cvalid && bus.cache_ready;

    assign w_ready8      = w_grant ? (8'd1 << w_winner) : 8'd0;
    assign bus.req_ready = w_ready8[NUM_PROCS-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr  <= 3'd0;
            r_wr  <= '0;
            r_rd  <= '0;
            r_occ <= '0;
            r_ill <= 8'd0;
        end else begin
            if (w_push) begin
                r_wr <= r_wr + AW'(1);
            end
            if (w_pop) begin
                r_rd <= r_rd + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_occ <= r_occ + OW'(1);
            end else if (w_pop && !w_push) begin
                r_occ <= r_occ - OW'(1);
            end
            if (w_grant) begin
                r_rr <= w_rr_next;
            end
            if (w_grant && !w_legal && r_ill != 8'hFF) begin
                r_ill <= r_ill + 8'd1;
            end
        end
    end

    // Storage needs no reset: every read is masked by occupancy.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_n[r_wr]    <= w_win_n;
            r_mem_addr[r_wr] <= w_win_addr;
            r_mem_pid[r_wr]  <= w_winner;
        end
    end

    logic [3:0]  w_head_n;
    logic [31:0] w_head_addr;
    logic [2:0]  w_head_pid;

    assign w_head_n    = w_cvalid ? r_mem_n[r_rd]    : 4'd0;
    assign w_head_addr = w_cvalid ? r_mem_addr[r_rd] : 32'd0;
    assign w_head_pid  = w_cvalid ? r_mem_pid[r_rd]  : 3'd0;

    assign bus.cache_valid   = w_cvalid;
    assign bus.cache_n       = w_head_n;
    assign bus.cache_tag     = w_head_addr[31:20];
    assign bus.cache_set     = w_head_addr[19:6];
    assign bus.cache_offset  = w_head_addr[5:0];
    assign bus.cache_pid     = w_head_pid;
    assign bus.cache_isel    = w_cvalid && (w_head_n == 4'd2);
    assign bus.occupancy     = r_occ;
    assign bus.illegal_count = r_ill;
endmodule

// File: tb/tb_cache_request_arbiter.sv
// Randomized bench for cache_request_arbiter with queue-based model.
// Literal checks pin the directed scenarios.
module tb_cache_request_arbiter;
    localparam int NP = 3;
    localparam int FD = 4;

    logic clk;
    logic rst;

    cache_request_arbiter_if #(.NUM_PROCS(NP), .FIFO_DEPTH(FD)) bus();

    cache_request_arbiter #(.NUM_PROCS(NP), .FIFO_DEPTH(FD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  n;
        logic [31:0] a;
        logic [2:0]  pid;
    } ent_t;

    ent_t q[$];
    int   m_rr;
    int   m_ill;
    int   total;
    int   bad;
    int   g;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    task automatic set_req(input int p, input bit v, input logic [3:0] n,
                           input logic [31:0] a);
        bus.req_valid[p]       = v;
        bus.req_n[4*p +: 4]    = n;
        bus.req_addr[32*p +: 32] = a;
    endtask

    function automatic int model_winner();
        for (int k = 0; k < NP; k++) begin
            int idx;
            idx = (m_rr + k) % NP;
            if (bus.req_valid[idx]) return idx;
        end
        return -1;
    endfunction

    // Compare at negedge, advance model at posedge, return at posedge+1.
    task automatic tick(output int gw);
        int         w;
        logic [NP-1:0] er;
        ent_t       h;
        ent_t       e;
        @(negedge clk);
        w  = model_winner();
        er = '0;
        if (w >= 0 && q.size() < FD) er[w] = 1'b1;
        check("req_ready", 32'(bus.req_ready), 32'(er));
        check("cache_valid", 32'(bus.cache_valid), 32'(q.size() != 0));
        check("occupancy", 32'(bus.occupancy), 32'(q.size()));
        check("illegal_count", 32'(bus.illegal_count), 32'(m_ill));
        if (q.size() != 0) begin
            h = q[0];
            check("cache_n", 32'(bus.cache_n), 32'(h.n));
            check("cache_tag", 32'(bus.cache_tag), 32'(h.a[31:20]));
            check("cache_set", 32'(bus.cache_set), 32'(h.a[19:6]));
            check("cache_offset", 32'(bus.cache_offset), 32'(h.a[5:0]));
            check("cache_pid", 32'(bus.cache_pid), 32'(h.pid));
            check("cache_isel", 32'(bus.cache_isel), 32'(h.n == 4'd2));
        end else begin
            check("idle_n_pid_isel",
                  32'({bus.cache_n, bus.cache_pid, bus.cache_isel}), 32'd0);
            check("idle_addr",
                  {bus.cache_tag, bus.cache_set, bus.cache_offset}, 32'd0);
        end
        @(posedge clk);
        if (q.size() != 0 && bus.cache_ready) void'(q.pop_front());
        gw = -1;
        if (er != '0) begin
            gw    = w;
            e.n   = bus.req_n[4*w +: 4];
            e.a   = bus.req_addr[32*w +: 32];
            e.pid = 3'(w);
            if (e.n <= 4'd4) q.push_back(e);
            else if (m_ill < 255) m_ill++;
            m_rr = (w + 1) % NP;
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        q.delete();
        m_rr  = 0;
        m_ill = 0;
        bus.req_valid   = '0;
        bus.req_n       = '0;
        bus.req_addr    = '0;
        bus.cache_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic all_legal();
        for (int p = 0; p < NP; p++)
            set_req(p, 1'b1, 4'($urandom_range(0, 4)), $urandom);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        do_reset();

        // Reset state, with requests pending during reset.
        rst = 1'b1;
        bus.req_valid = '1;
        #1;
        check("rst_ready", 32'(bus.req_ready), 32'd0);
        check("rst_valid", 32'(bus.cache_valid), 32'd0);
        check("rst_occ", 32'(bus.occupancy), 32'd0);
        check("rst_ill", 32'(bus.illegal_count), 32'd0);
        do_reset();

        // Single request from P1.
        bus.cache_ready = 1'b1;
        set_req(1, 1'b1, 4'd0, 32'h984DE132);
        #1 check("t1_ready", 32'(bus.req_ready), 32'b010);
        tick(g);
        set_req(1, 1'b0, 4'd0, 32'd0);
        #1;
        check("t1_valid", 32'(bus.cache_valid), 32'd1);
        check("t1_tag", 32'(bus.cache_tag), 32'h984);
        check("t1_set", 32'(bus.cache_set), 32'h3784);
        check("t1_off", 32'(bus.cache_offset), 32'h32);
        check("t1_pid", 32'(bus.cache_pid), 32'd1);
        check("t1_isel", 32'(bus.cache_isel), 32'd0);
        tick(g);
        #1 check("t1_occ", 32'(bus.occupancy), 32'd0);

        // Round-robin fairness with everyone requesting.
        do_reset();
        bus.cache_ready = 1'b1;
        all_legal();
        for (int k = 0; k < 9; k++) begin
            #1 check("rr_grant", 32'(bus.req_ready), 32'(1 << (k % NP)));
            tick(g);
            if (g >= 0) set_req(g, 1'b1, 4'($urandom_range(0, 4)), $urandom);
        end

        // Backpressure: 4 accepted, 5th blocked until after first pop.
        do_reset();
        all_legal();
        for (int k = 0; k < 4; k++) begin
            tick(g);
            if (g >= 0) set_req(g, 1'b1, 4'($urandom_range(0, 4)), $urandom);
        end
        #1;
        check("bp_occ", 32'(bus.occupancy), 32'd4);
        check("bp_ready", 32'(bus.req_ready), 32'd0);
        tick(g);
        tick(g);
        bus.cache_ready = 1'b1;
        #1 check("bp_pop_cycle_ready", 32'(bus.req_ready), 32'd0);
        tick(g);
        #1;
        check("bp_occ3", 32'(bus.occupancy), 32'd3);
        check("bp_next_grant", 32'(bus.req_ready), 32'b010);
        tick(g);
        bus.req_valid = '0;
        repeat (6) tick(g);

        // Opcode steering and an illegal opcode.
        do_reset();
        bus.cache_ready = 1'b1;
        set_req(0, 1'b1, 4'd2, 32'h116DE12F);
        #1 check("op_ready", 32'(bus.req_ready), 32'b001);
        tick(g);
        set_req(0, 1'b1, 4'd9, $urandom);
        #1;
        check("op_isel", 32'(bus.cache_isel), 32'd1);
        check("op_set", 32'(bus.cache_set), 32'h3784);
        check("op_ill_ready", 32'(bus.req_ready), 32'b001);
        tick(g);
        set_req(0, 1'b0, 4'd0, 32'd0);
        #1;
        check("op_ill_cnt", 32'(bus.illegal_count), 32'd1);
        check("op_not_presented", 32'(bus.cache_valid), 32'd0);
        tick(g);

        // Sustained throughput across pointer wrap.
        do_reset();
        bus.cache_ready = 1'b1;
        all_legal();
        for (int k = 0; k < 3 * FD; k++) begin
            tick(g);
            if (g >= 0) set_req(g, 1'b1, 4'($urandom_range(0, 4)), $urandom);
            #1 check("wrap_occ", 32'(bus.occupancy), 32'd1);
        end
        bus.req_valid = '0;
        repeat (2) tick(g);

        // Random traffic including illegal opcodes and backpressure.
        do_reset();
        for (int k = 0; k < 400; k++) begin
            for (int p = 0; p < NP; p++)
                set_req(p, 1'($urandom_range(0, 1)),
                        4'($urandom_range(0, 7)), $urandom);
            bus.cache_ready = ($urandom_range(0, 3) != 0);
            tick(g);
        end

        // Illegal counter saturation.
        do_reset();
        bus.cache_ready = 1'b1;
        for (int k = 0; k < 270; k++) begin
            for (int p = 0; p < NP; p++)
                set_req(p, 1'b1, 4'($urandom_range(5, 15)), $urandom);
            tick(g);
        end
        #1 check("ill_sat", 32'(bus.illegal_count), 32'd255);

        // Asynchronous reset with three entries queued.
        do_reset();
        all_legal();
        repeat (3) tick(g);
        #1 check("mid_occ3", 32'(bus.occupancy), 32'd3);
        rst = 1'b1;
        q.delete();
        m_rr  = 0;
        m_ill = 0;
        #1;
        check("mid_valid", 32'(bus.cache_valid), 32'd0);
        check("mid_occ", 32'(bus.occupancy), 32'd0);
        check("mid_ready", 32'(bus.req_ready), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        #1 check("mid_first_grant", 32'(bus.req_ready), 32'b001);
        repeat (3) tick(g);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
